// File: rtl/uart_sr_tx_if.sv
// Handshake and serial-line bundle between the TX data-register FIFO and the UART shift register.
interface uart_sr_tx_if;
    logic [7:0] in;
    logic       in_valid;
    logic       sr_empty;
    logic       tx;
    logic       busy;

    modport master (output in, output in_valid, input sr_empty, input tx, input busy);
    modport slave  (input in, input in_valid, output sr_empty, output tx, output busy);
endinterface

// File: rtl/uart_sr_tx.sv
// UART transmit shift register: takes one byte from the FIFO head and frames it
// as start, 8 data bits LSB first, optional parity and 1 or 2 stop bits.
module uart_sr_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic          clk,
    input  logic          rst,
    uart_sr_tx_if.slave   bus
);

    localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic            STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic            PAR_INV   = 1'(PARITY_ODD);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        r_state,    w_stateNext;
    logic [CW-1:0] r_baudCnt,  w_baudCntNext;
    logic [2:0]    r_bitIdx,   w_bitIdxNext;
    logic [7:0]    r_shift,    w_shiftNext;
    logic          r_stopCnt,  w_stopCntNext;
    logic          r_tx,       w_txNext;
    logic          r_srEmpty,  w_srEmptyNext;
    logic          w_bitDone;

    assign w_bitDone = (r_baudCnt == BAUD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_shift   <= '0;
            r_stopCnt <= 1'b0;
            r_tx      <= 1'b1;
            r_srEmpty <= 1'b1;
        end else begin
            r_state   <= w_stateNext;
            r_baudCnt <= w_baudCntNext;
            r_bitIdx  <= w_bitIdxNext;
            r_shift   <= w_shiftNext;
            r_stopCnt <= w_stopCntNext;
            r_tx      <= w_txNext;
            r_srEmpty <= w_srEmptyNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_baudCntNext = r_baudCnt;
        w_bitIdxNext  = r_bitIdx;
        w_shiftNext   = r_shift;
        w_stopCntNext = r_stopCnt;

        if (r_state != IDLE) begin
            w_baudCntNext = w_bitDone ? '0 : r_baudCnt + 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_shiftNext   = bus.in;
                    w_baudCntNext = '0;
                    w_bitIdxNext  = '0;
                    w_stopCntNext = 1'b0;
                    w_stateNext   = START;
                end
            end
            START: begin
                if (w_bitDone) w_stateNext = DATA;
            end
            DATA: begin
                if (w_bitDone) begin
                    if (r_bitIdx == 3'd7) begin
                        w_bitIdxNext  = '0;
                        w_stopCntNext = 1'b0;
                        w_stateNext   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        w_bitIdxNext = r_bitIdx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (w_bitDone) begin
                    w_stopCntNext = 1'b0;
                    w_stateNext   = STOP;
                end
            end
            STOP: begin
                if (w_bitDone) begin
                    if (r_stopCnt == STOP_LAST) w_stateNext = IDLE;
                    else                        w_stopCntNext = 1'b1;
                end
            end
            default: w_stateNext = IDLE;
        endcase

        // Line level is decoded from the upcoming state so tx and sr_empty come straight from flops.
        w_txNext = 1'b1;
        case (w_stateNext)
            START:   w_txNext = 1'b0;
            DATA:    w_txNext = w_shiftNext[w_bitIdxNext];
            PARITY:  w_txNext = (^w_shiftNext) ^ PAR_INV;
            default: w_txNext = 1'b1;
        endcase
        w_srEmptyNext = (w_stateNext == IDLE);
    end

    assign bus.tx       = r_tx;
    assign bus.sr_empty = r_srEmpty;
    assign bus.busy     = ~r_srEmpty;

endmodule

// File: doc/uart_sr_tx.md
UART_SR_TX -- requirements
Module: uart_sr_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter PARITY_EN, default 0: 1 inserts a parity bit after data bit 7.
REQ-003 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-004 SHALL have parameter STOP_BITS, default 1: number of stop bits; legal values 1 or 2.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in  input  8  byte from the upstream TX data-register FIFO head.
REQ-008 SHALL have port in_valid  input  1  upstream pop strobe; its high level means the byte on in is being handed over this cycle.
REQ-009 SHALL have port sr_empty  output  1  high = shift register idle and able to take a byte; feeds the upstream FIFO.
REQ-010 SHALL have port tx  output  1  serial line; idle level is high.
REQ-011 SHALL have port busy  output  1  high while a frame is being shifted out; always equal to ~sr_empty.

Function
REQ-012 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL hold sr_empty=1 in IDLE only; sr_empty and tx SHALL be registered outputs.
REQ-014 SHALL accept a byte on any edge with state=IDLE and in_valid=1: latch in into the shift register, clear the baud counter, clear the bit index, and go to START.
REQ-015 SHALL drive sr_empty=0 from the cycle after acceptance, so the upstream pops exactly one entry per frame.
REQ-016 SHALL ignore in_valid in every state other than IDLE: no latch and no state change.
REQ-017 SHALL drive tx=0 throughout START, starting the cycle after acceptance; this is a one-cycle accept-to-line latency.
REQ-018 SHALL hold every bit (start, data, parity, stop) on tx for exactly CLKS_PER_BIT cycles, timed by a baud counter of width clog2(CLKS_PER_BIT) that counts 0..CLKS_PER_BIT-1 and wraps to 0.
REQ-019 SHALL shift data LSB first in DATA (bit 0..7) using a 3-bit bit index, and leave DATA after bit index 7 completes.
REQ-020 SHALL go DATA->PARITY when PARITY_EN=1, otherwise DATA->STOP.
REQ-021 SHALL set the parity bit to XOR of the 8 latched data bits, inverted when PARITY_ODD=1.
REQ-022 SHALL drive tx=1 in STOP for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE with sr_empty=1.
REQ-023 SHALL have a frame length (acceptance+1 to IDLE entry) of exactly (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-024 SHALL, for back-to-back bytes, accept the next byte no earlier than the first IDLE cycle; tx stays high during that gap of at least 1 cycle.
REQ-025 SHALL drive tx=1 whenever state is IDLE or STOP.
REQ-026 SHALL leave the latched byte unchanged when in changes mid-frame.

Reset
REQ-027 SHALL, while rst=0, immediately force state=IDLE, tx=1, sr_empty=1, busy=0, baud counter=0, bit index=0, shift register=0x00.
REQ-028 SHALL abort any frame in progress when rst asserts mid-frame; the partial frame is not resumed after rst deasserts.
REQ-029 SHALL be able to accept a byte on the first rising edge after rst deasserts.

Verification
REQ-030 SHALL cover: CLKS_PER_BIT=4, 8N1, send 0xA5 -> tx = 0 (4 cycles), then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 (4 cycles); sr_empty low for exactly 40 cycles.
REQ-031 SHALL cover: PARITY_EN=1, send 0xA5 -> parity bit 0 for even and 1 for odd; frame lasts 44 cycles.
REQ-032 SHALL cover: STOP_BITS=2, send 0xFF -> tx high for 8 stop cycles; frame lasts 44 cycles.
REQ-033 SHALL cover: in_valid pulsed with 0x01 then 0x80 on the first IDLE cycle -> two complete frames, exactly one pop each, no data corruption.
REQ-034 SHALL cover: rst asserted during data bit 3 of 0x3C -> tx=1 and sr_empty=1 immediately; a byte offered after rst release transmits correctly.
REQ-035 SHALL cover: in_valid=1 with in=0xFF during a 0x00 frame -> byte ignored, transmitted frame unchanged.
